mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//   Round-robin burst arbiter sharing one DATA_W-bit output bus among NUM_REQ requesters.
//   Sequences the wide output mux select, grants one requester at a time for up to MAX_BURST beats,
//   and registers the selected data into a single-entry output stage with valid/ready backpressure.
//   Sits between multiple producer blocks and one shared downstream consumer.
// PARAMETERS
//   NUM_REQ    4   number of requesters, >= 2
//   DATA_W     4   width of each requester data word and of out_data
//   MAX_BURST  4   max beats per grant before forced rotation, >= 1
//   ID_W       $clog2(NUM_REQ)   localparam, width of grant_id
// PORTS
//   clk        in   1               single clock, rising edge
//   rst_n      in   1               asynchronous active-low reset
//   req_valid  in   NUM_REQ         per-requester data valid
//   req_data   in   NUM_REQ*DATA_W  flat data bus, requester i at [i*DATA_W +: DATA_W]
//   req_ready  out  NUM_REQ         per-requester accept, at most one bit set
//   out_valid  out  1               output word valid
//   out_data   out  DATA_W          output word
//   out_ready  in   1               downstream accept
//   grant_id   out  ID_W            index of current/last granted requester
//   busy       out  1               1 while in BURST state
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, out_valid=0, out_data=0,
//     req_ready=0, busy=0. An in-flight output word is discarded; no partial state survives.
//   States: IDLE, BURST.
//   IDLE: req_ready=0. If any req_valid: grant g = first i with req_valid[i], searching
//     rr_ptr, rr_ptr+1, ... modulo NUM_REQ; grant_id<=g, beat_cnt<=0, go BURST. Else stay.
//   BURST: stage_free = !out_valid || out_ready. req_ready[g] = stage_free; others 0.
//     Beat accepted when req_valid[g] && req_ready[g]: out_data<=req_data[g], out_valid<=1,
//     beat_cnt<=beat_cnt+1. Latency: accepted word appears on out_data the next cycle.
//     Exit to IDLE, rr_ptr<=(g+1) mod NUM_REQ, when either:
//       (a) accepted beat is beat number MAX_BURST (beat_cnt==MAX_BURST-1), or
//       (b) req_valid[g]==0 (requester ended burst; no beat accepted that cycle).
//     Stalled cycles (req_ready[g]=0) never count toward MAX_BURST and never trigger exit (a).
//   Output stage: out_valid cleared when out_valid && out_ready && no new beat accepted same cycle;
//     simultaneous drain and accept keeps out_valid=1 with new data (full throughput).
//     out_data holds stable while out_valid && !out_ready.
//   Requester protocol: req_data must be held while req_valid && !req_ready.
//   Arbitration bubble: exactly one IDLE cycle between consecutive bursts, incl. same requester.
//   Pointer wrap: rr_ptr increments modulo NUM_REQ (NUM_REQ-1 -> 0); non-power-of-2 NUM_REQ legal.
//   New requests arriving during BURST wait; never preempt the current grant.
//   busy=1 iff state==BURST; grant_id holds last grant while IDLE.
// TESTING (NUM_REQ=4, DATA_W=4, MAX_BURST=4)
//   1. Hold rst_n=0 with random inputs -> out_valid=0, out_data=0, req_ready=0, busy=0, grant_id=0.
//   2. Only req 2 valid, data A,B,C then valid drops, out_ready=1 -> grant_id=2, out_data A,B,C on
//      consecutive cycles 1 cycle after accept, IDLE after drop, next search starts at 3.
//   3. All 4 valid continuously, out_ready=1 -> bursts of exactly 4 beats in order 0,1,2,3,0,
//      one IDLE cycle between bursts, 16 beats in 20 cycles.
//   4. Mid-burst out_ready=0 for 3 cycles -> req_ready[g]=0 after stage fills, out_data stable,
//      no lost/duplicated words, beat_cnt frozen, burst still ends after 4 accepted beats.
//   5. rr_ptr=3 (after grant 2), req 0 and 3 valid -> 3 granted first, then 0 (wrap).
//   6. Assert rst_n=0 mid-burst with out_valid=1 -> out_valid=0 immediately (no clock edge),
//      after release state IDLE, rr_ptr=0, req 0 granted first if valid.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter: one requester owns the shared bus for up to MAX_BURST beats; one IDLE cycle between grants.
// Accepted word appears on out_data one cycle later; req_ready drops while the single output stage is full and out_ready is low.
module mux_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    input  logic                        out_ready,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   pick;
    logic [ID_W-1:0]   next_ptr;
    logic [CNT_W-1:0]  beat_cnt;
    logic              found;
    logic              stage_free;
    logic              accept;
    logic              burst_end;
    logic [DATA_W-1:0] sel_data;
    int                idx;

    // First valid requester at or after rr_ptr, wrapping without relying on power-of-2 NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    end

    assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    assign sel_data = req_data[int'(grant_id)*DATA_W +: DATA_W];
    assign busy     = (state == BURST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        accept     = 1'b0;
        burst_end  = 1'b0;
        stage_free = !out_valid || out_ready;
        case (state)
            IDLE: begin
                if (found) state_nxt = BURST;
            end
            BURST: begin
                req_ready[grant_id] = stage_free;
                accept    = req_valid[grant_id] && stage_free;
                // Stalled cycles leave beat_cnt untouched, so only real beats move toward the limit.
                burst_end = !req_valid[grant_id] ||
                            (accept && (beat_cnt == CNT_W'(MAX_BURST - 1)));
                if (burst_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            grant_id  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (state == IDLE && found) begin
                grant_id <= pick;
                beat_cnt <= '0;
            end
            if (accept) begin
                out_data <= sel_data;
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (burst_end) rr_ptr <= next_ptr;
            if (accept)         out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: per-requester source queues, expected words queued at issue, monitor pops on each transfer.
module tb_mux_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic        out_ready = 1'b1;
    logic [1:0]  grant_id;
    logic        busy;

    int checks = 0;
    int passed = 0;
    bit drv_en = 1'b0;

    logic [3:0] src [4][$];
    logic [3:0] exp_q [$];

    mux_rr_arbiter #(.NUM_REQ(4), .DATA_W(4), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Queue a word on requester r and expect it on the output in issue order.
    task automatic issue(input int r, input logic [3:0] w);
        src[r].push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_busy(input logic val, input string name);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (busy === val) return;
        end
        checks++;
        $display("FAIL %s: busy never reached %0b", name, val);
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && busy === 1'b0 && req_valid == 4'b0) return;
        end
        checks++;
        $display("FAIL %s: %0d words still expected", name, exp_q.size());
    endtask

    // Requester model: holds data until req_ready is seen, then advances its queue.
    initial begin
        logic [3:0] hs;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (drv_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (hs[i] && src[i].size() > 0) void'(src[i].pop_front());
                    req_valid[i] = (src[i].size() > 0);
                    req_data[i*4 +: 4] = (src[i].size() > 0) ? src[i][0] : 4'h0;
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL extra_word: got %0h expected none at %0t", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_word", 32'(out_data), 32'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt, icnt;

        // 1: reset held with random inputs
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            req_valid = 4'($urandom);
            req_data  = 16'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_out_data",  32'(out_data), 0);
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_busy",      32'(busy), 0);
            chk("rst_grant_id",  32'(grant_id), 0);
        end
        req_valid = '0; req_data = '0; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        drv_en = 1'b1;
        @(negedge clk);

        // 3: all four valid, bursts of 4 in order 0,1,2,3,0
        for (int j = 0; j < 4; j++) issue(0, {2'd0, 2'(j)});
        for (int r = 1; r < 4; r++)
            for (int j = 0; j < 4; j++) issue(r, {2'(r), 2'(j)});
        for (int j = 0; j < 4; j++) issue(0, {2'd0, 2'(3 - j)});
        wait_busy(1'b1, "t3_start");
        chk("t3_first_grant", 32'(grant_id), 0);
        vcnt = 0; icnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (out_valid) vcnt++;
            if (!busy) icnt++;
        end
        chk("t3_beats_in_20", 32'(vcnt), 16);
        chk("t3_idle_cycles", 32'(icnt), 4);
        wait_drain("t3_drain");

        // 2: single requester 2, words A,B,C then valid drops
        issue(2, 4'hA); issue(2, 4'hB); issue(2, 4'hC);
        wait_busy(1'b1, "t2_start");
        chk("t2_grant_id", 32'(grant_id), 2);
        chk("t2_req_ready", 32'(req_ready), 32'h4);
        @(negedge clk); chk("t2_data_a", 32'(out_data), 32'hA);
        @(negedge clk); chk("t2_data_b", 32'(out_data), 32'hB);
        @(negedge clk); chk("t2_data_c", 32'(out_data), 32'hC);
        @(negedge clk);
        chk("t2_idle_after_drop", 32'(busy), 0);
        chk("t2_out_cleared", 32'(out_valid), 0);
        wait_drain("t2_drain");

        // 5: pointer at 3, requesters 0 and 3 -> 3 first, then wrap to 0
        issue(3, 4'hD); issue(3, 4'hE);
        issue(0, 4'h1); issue(0, 4'h2);
        wait_busy(1'b1, "t5_start");
        chk("t5_first_grant", 32'(grant_id), 3);
        wait_busy(1'b0, "t5_gap");
        wait_busy(1'b1, "t5_second");
        chk("t5_wrap_grant", 32'(grant_id), 0);
        wait_drain("t5_drain");

        // 4: pointer at 1, stall output 3 cycles mid-burst
        for (int j = 0; j < 5; j++) issue(1, 4'(4 + j));
        wait_busy(1'b1, "t4_start");
        chk("t4_grant", 32'(grant_id), 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_stall_ready", 32'(req_ready), 0);
            chk("t4_stall_data", 32'(out_data), 32'h4);
            chk("t4_stall_valid", 32'(out_valid), 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t4_still_busy_beat3", 32'(busy), 1);
        @(negedge clk);
        chk("t4_end_after_4_beats", 32'(busy), 0);
        chk("t4_last_beat_data", 32'(out_data), 32'h7);
        wait_drain("t4_drain");

        // 6: reset mid-burst with a word in the output stage
        issue(2, 4'h9); issue(2, 4'hA); issue(2, 4'hB);
        wait_busy(1'b1, "t6_start");
        @(negedge clk);
        drv_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_async_out_valid", 32'(out_valid), 0);
        chk("t6_async_busy", 32'(busy), 0);
        chk("t6_async_req_ready", 32'(req_ready), 0);
        chk("t6_async_grant_id", 32'(grant_id), 0);
        for (int i = 0; i < 4; i++) src[i].delete();
        exp_q.delete();
        req_valid = '0; req_data = '0;
        @(negedge clk);
        @(negedge clk);
        issue(0, 4'h3); issue(0, 4'h5);
        issue(2, 4'h6); issue(2, 4'h8);
        rst_n = 1'b1;
        drv_en = 1'b1;
        @(negedge clk);
        chk("t6_idle_after_release", 32'(busy), 0);
        wait_busy(1'b1, "t6_regrant");
        chk("t6_ptr_reset_grant", 32'(grant_id), 0);
        wait_drain("t6_drain");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
